// File: rtl/seq_pkg.sv
// Shared types and constants for the audio frame sequencer.
package seq_pkg;

  localparam int unsigned DATA_W = 10;
  localparam int unsigned STAT_W = 8;
  localparam logic [DATA_W-1:0] MIDSCALE = 10'd512;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ADC_WAIT  = 2'd1,
    PROC_WAIT = 2'd2
  } seq_state_e;

  // Bits needed to hold values 0..v (at least one bit).
  function automatic int unsigned bits_for(input int unsigned v);
    return (v < 1) ? 1 : $clog2(v + 1);
  endfunction

endpackage

// File: rtl/seq_tick_gen.sv
// Sample-rate divider: one tick every DIV+1 cycles while enabled.
module seq_tick_gen
  import seq_pkg::*;
#(
  parameter int unsigned DIV = 4999
) (
  input  logic sysclk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CNT_W = bits_for(DIV);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count and tick; counter parks at 0 while disabled.
  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (!enable) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DIV)) begin
      cnt_d = '0;
      tick  = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sample_sequencer.sv
// Per-frame ADC -> processor -> DAC sequencer with overrun and timeout status.
module sample_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned DIV          = 4999,
  parameter int unsigned ADC_TIMEOUT  = 2047,
  parameter int unsigned PROC_TIMEOUT = 1023
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              enable,
  input  logic              clr_stat,
  output logic              adc_start,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] adc_data,
  output logic              proc_start,
  output logic [DATA_W-1:0] proc_data,
  input  logic              proc_done,
  input  logic [DATA_W-1:0] proc_result,
  output logic              dac_start,
  output logic [DATA_W-1:0] dac_data,
  output logic [STAT_W-1:0] overrun_cnt,
  output logic              timeout_err,
  output logic [1:0]        state_dbg
);

  localparam int unsigned TMR_MAX = (ADC_TIMEOUT > PROC_TIMEOUT) ? ADC_TIMEOUT : PROC_TIMEOUT;
  localparam int unsigned TMR_W   = bits_for(TMR_MAX);

  logic tick;

  seq_state_e        state_q,      state_d;
  logic [TMR_W-1:0]  timer_q,      timer_d;
  logic              adc_start_q,  adc_start_d;
  logic              proc_start_q, proc_start_d;
  logic [DATA_W-1:0] proc_data_q,  proc_data_d;
  logic              dac_start_q,  dac_start_d;
  logic [DATA_W-1:0] dac_data_q,   dac_data_d;
  logic [STAT_W-1:0] overrun_q,    overrun_d;
  logic              timeout_q,    timeout_d;
  logic              drop;
  logic              tmo_hit;

  seq_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .sysclk (sysclk),
    .reset  (reset),
    .enable (enable),
    .tick   (tick)
  );

  // Frame FSM, wait timer, datapath captures and status counters.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    adc_start_d  = 1'b0;
    proc_start_d = 1'b0;
    dac_start_d  = 1'b0;
    proc_data_d  = proc_data_q;
    dac_data_d   = dac_data_q;
    overrun_d    = overrun_q;
    timeout_d    = timeout_q;
    tmo_hit      = 1'b0;
    drop         = tick && (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        if (tick) begin
          adc_start_d = 1'b1;
          timer_d     = TMR_W'(ADC_TIMEOUT);
          state_d     = ADC_WAIT;
        end
      end
      ADC_WAIT: begin
        // A valid in the timer==0 cycle still completes the conversion.
        if (adc_valid) begin
          proc_data_d  = adc_data;
          proc_start_d = 1'b1;
          timer_d      = TMR_W'(PROC_TIMEOUT);
          state_d      = PROC_WAIT;
        end else if (timer_q == '0) begin
          tmo_hit = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      PROC_WAIT: begin
        if (proc_done) begin
          dac_data_d  = proc_result;
          dac_start_d = 1'b1;
          timer_d     = '0;
          state_d     = IDLE;
        end else if (timer_q == '0) begin
          tmo_hit = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      default: begin
        timer_d = '0;
        state_d = IDLE;
      end
    endcase

    // Clearing wins over a same-cycle increment or timeout.
    if (clr_stat) begin
      overrun_d = '0;
      timeout_d = 1'b0;
    end else begin
      if (drop && (overrun_q != {STAT_W{1'b1}})) begin
        overrun_d = overrun_q + STAT_W'(1);
      end
      if (tmo_hit) begin
        timeout_d = 1'b1;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      adc_start_q  <= 1'b0;
      proc_start_q <= 1'b0;
      proc_data_q  <= '0;
      dac_start_q  <= 1'b0;
      dac_data_q   <= MIDSCALE;
      overrun_q    <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      adc_start_q  <= adc_start_d;
      proc_start_q <= proc_start_d;
      proc_data_q  <= proc_data_d;
      dac_start_q  <= dac_start_d;
      dac_data_q   <= dac_data_d;
      overrun_q    <= overrun_d;
      timeout_q    <= timeout_d;
    end
  end

  assign adc_start   = adc_start_q;
  assign proc_start  = proc_start_q;
  assign proc_data   = proc_data_q;
  assign dac_start   = dac_start_q;
  assign dac_data    = dac_data_q;
  assign overrun_cnt = overrun_q;
  assign timeout_err = timeout_q;
  assign state_dbg   = 2'(state_q);

endmodule

// File: doc/sample_sequencer.md
# sample_sequencer

Frame-level controller for the 10 kHz audio datapath. Generates the sample tick internally and, once per frame, runs ADC conversion, processor step and DAC write in strict order. It replaces free-running tick fan-out to the ADC, processor and DAC, so each frame's sample moves through the chain exactly once. It sits between the SPI ADC interface, the processing block and the SPI DAC/PWM outputs, and reports overruns and timeouts.

## Interface
- DIV, 4999: tick divider terminal count; frame period = DIV+1 sysclk cycles (10 kHz at 50 MHz).
- ADC_TIMEOUT, 2047: max cycles waited for adc_valid after adc_start.
- PROC_TIMEOUT, 1023: max cycles waited for proc_done after proc_start.
- sysclk  in  1  system clock (50 MHz); all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  high = frames run; low = tick counter held at 0.
- clr_stat  in  1  one-cycle pulse; clears overrun_cnt and timeout_err.
- adc_start  out  1  one-cycle pulse starting an ADC conversion.
- adc_valid  in  1  one-cycle pulse, adc_data valid.
- adc_data  in  10  converted sample.
- proc_start  out  1  one-cycle pulse, proc_data valid.
- proc_data  out  10  sample handed to processor, held until next update.
- proc_done  in  1  one-cycle pulse, proc_result valid.
- proc_result  in  10  processed sample.
- dac_start  out  1  one-cycle pulse to DAC and PWM loaders.
- dac_data  out  10  sample to DAC/PWM, held between updates.
- overrun_cnt  out  8  saturating count of ticks dropped (frame still busy).
- timeout_err  out  1  sticky flag: ADC or processor timeout occurred.
- state_dbg  out  2  current FSM state encoding.

## Operation
- FSM states: IDLE(0), ADC_WAIT(1), PROC_WAIT(2).
- IDLE + tick: pulse adc_start, load timer = ADC_TIMEOUT, go ADC_WAIT.
- ADC_WAIT + adc_valid: proc_data <= adc_data, pulse proc_start, load timer = PROC_TIMEOUT, go PROC_WAIT.
- ADC_WAIT, timer == 0, no adc_valid: set timeout_err, go IDLE; dac_data unchanged, no dac_start.
- PROC_WAIT + proc_done: dac_data <= proc_result, pulse dac_start, go IDLE.
- PROC_WAIT, timer == 0, no proc_done: set timeout_err, go IDLE.
- Timer decrements by 1 each cycle in a wait state. A valid/done pulse in the cycle the timer hits 0 wins over timeout.
- adc_valid in IDLE/PROC_WAIT and proc_done in IDLE/ADC_WAIT are ignored.
- A tick in any state other than IDLE is dropped and overrun_cnt increments, saturating at 255. This includes the cycle the FSM returns to IDLE.
- clr_stat takes priority over a same-cycle increment or timeout set.
- enable low: no new ticks; an in-flight frame completes normally.
- Reset (anytime, incl. mid-frame): state IDLE, tick counter 0, all pulses 0, proc_data 0, dac_data 512 (midscale), overrun_cnt 0, timeout_err 0, timer 0.

## Timing
- The tick counter counts 0..DIV and wraps. tick is high in the cycle where counter == DIV and enable is high.
- All outputs are registered. adc_start is high in the cycle after tick.
- adc_valid sampled at edge k -> proc_start and new proc_data visible after edge k, same cycle.
- proc_done sampled at edge k -> dac_start and new dac_data visible after edge k.
- Pulse outputs are exactly 1 cycle wide. Data outputs change only with their strobe.
- Minimum frame: tick -> adc_start (+1) -> adc_valid -> proc_start (+1) -> proc_done -> dac_start (+1).

## Structure
- Package seq_pkg: DATA_W = 10, MIDSCALE = 10'd512, the state enum (IDLE, ADC_WAIT, PROC_WAIT), STAT_W = 8.
- Sub-module seq_tick_gen (parameter DIV; ports sysclk, reset, enable, tick) holds the divider. The FSM, timer and status logic stay in sample_sequencer.

## Test plan
- Reset released, DIV=9, enable=1: adc_start at cycle 10. Model answers adc_valid 100 cycles later with 0x2A5 -> proc_start next cycle, proc_data = 0x2A5. proc_done with 0x155 -> dac_start, dac_data = 0x155. State returns to IDLE.
- ADC model never answers, ADC_TIMEOUT=15: timeout_err set 16 cycles after adc_start, dac_data stays 512, no dac_start. Next tick starts a new frame.
- Processor slow (proc_done 25 cycles after proc_start), DIV=19: overrun_cnt increments once per tick that lands outside IDLE. Force 300 such ticks -> overrun_cnt stays at 255.
- clr_stat in the same cycle as an overrun tick -> overrun_cnt = 0 and timeout_err = 0 next cycle.
- adc_valid in the exact cycle the timer reaches 0 -> proc_start issued, timeout_err stays 0.
- reset pulsed while in PROC_WAIT: outputs return to reset values immediately. A late proc_done after release is ignored; dac_data stays 512.
